// File: rtl/arm7tdmi_mul_sequencer.sv
// arm7tdmi_mul_sequencer: decodes ARM multiply instructions, fetches operands,
// drives the multiplier and writes results and N/Z flags back.
module arm7tdmi_mul_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [31:0] rf_rdata_a,
    input  logic [31:0] rf_rdata_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        mul_en,
    output logic        mul_long,
    output logic        mul_signed,
    output logic        mul_accumulate,
    output logic        mul_set_flags,
    output logic [1:0]  mul_type,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [31:0] acc_hi,
    output logic [31:0] acc_lo,
    input  logic [31:0] result_hi,
    input  logic [31:0] result_lo,
    input  logic        result_ready,
    input  logic        negative,
    input  logic        zero,
    output logic        flag_we,
    output logic        flag_n,
    output logic        flag_z
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_OPS,
        S_RD_ACC,
        S_EXEC,
        S_WB_LO,
        S_WB_HI,
        S_DONE
    } state_e;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e        state_q, state_d;
    logic          long_q, long_d;
    logic          sgn_q, sgn_d;
    logic          acc_q, acc_d;
    logic          set_q, set_d;
    logic [3:0]    rd_hi_q, rd_hi_d;
    logic [3:0]    rd_lo_q, rd_lo_d;
    logic [3:0]    rs_q, rs_d;
    logic [3:0]    rm_q, rm_d;
    logic [31:0]   op_a_q, op_a_d;
    logic [31:0]   op_b_q, op_b_d;
    logic [31:0]   acc_hi_q, acc_hi_d;
    logic [31:0]   acc_lo_q, acc_lo_d;
    logic [31:0]   res_hi_q, res_hi_d;
    logic [31:0]   res_lo_q, res_lo_d;
    logic          neg_q, neg_d;
    logic          zero_q, zero_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          wr_sel;

    // Opcode, condition and the fixed 1001 marker are not needed here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:24], instr[7:4]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            long_q   <= 1'b0;
            sgn_q    <= 1'b0;
            acc_q    <= 1'b0;
            set_q    <= 1'b0;
            rd_hi_q  <= '0;
            rd_lo_q  <= '0;
            rs_q     <= '0;
            rm_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            long_q   <= long_d;
            sgn_q    <= sgn_d;
            acc_q    <= acc_d;
            set_q    <= set_d;
            rd_hi_q  <= rd_hi_d;
            rd_lo_q  <= rd_lo_d;
            rs_q     <= rs_d;
            rm_q     <= rm_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        long_d     = long_q;
        sgn_d      = sgn_q;
        acc_d      = acc_q;
        set_d      = set_q;
        rd_hi_d    = rd_hi_q;
        rd_lo_d    = rd_lo_q;
        rs_d       = rs_q;
        rm_d       = rm_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        res_hi_d   = res_hi_q;
        res_lo_d   = res_lo_q;
        neg_d      = neg_q;
        zero_d     = zero_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        rf_raddr_a = 4'd0;
        rf_raddr_b = 4'd0;
        wr_sel     = 1'b0;
        rf_waddr   = 4'd0;
        rf_wdata   = 32'd0;
        flag_we    = 1'b0;
        done       = 1'b0;
        mul_en     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    long_d  = instr[23];
                    sgn_d   = instr[22] & instr[23];
                    acc_d   = instr[21];
                    set_d   = instr[20];
                    rd_hi_d = instr[19:16];
                    rd_lo_d = instr[15:12];
                    rs_d    = instr[11:8];
                    rm_d    = instr[3:0];
                    state_d = S_RD_OPS;
                end
            end
            S_RD_OPS: begin
                rf_raddr_a = rm_q;
                rf_raddr_b = rs_q;
                op_a_d     = rf_rdata_a;
                op_b_d     = rf_rdata_b;
                cnt_d      = '0;
                if (acc_q) begin
                    state_d = S_RD_ACC;
                end else begin
                    acc_hi_d = '0;
                    acc_lo_d = '0;
                    state_d  = S_EXEC;
                end
            end
            S_RD_ACC: begin
                // Short forms keep Rn in the same field as RdLo.
                rf_raddr_a = rd_lo_q;
                rf_raddr_b = long_q ? rd_hi_q : 4'd0;
                acc_lo_d   = rf_rdata_a;
                acc_hi_d   = long_q ? rf_rdata_b : 32'd0;
                cnt_d      = '0;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                mul_en = 1'b1;
                if (result_ready) begin
                    res_hi_d = result_hi;
                    res_lo_d = result_lo;
                    neg_d    = negative;
                    zero_d   = zero;
                    state_d  = S_WB_LO;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB_LO: begin
                wr_sel   = 1'b1;
                rf_waddr = long_q ? rd_lo_q : rd_hi_q;
                rf_wdata = res_lo_q;
                flag_we  = set_q & ~long_q;
                state_d  = long_q ? S_WB_HI : S_DONE;
            end
            S_WB_HI: begin
                wr_sel   = 1'b1;
                rf_waddr = rd_hi_q;
                rf_wdata = res_hi_q;
                flag_we  = set_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // R15 is never a legal multiply destination; drop the write only.
        rf_we = wr_sel & ~(&rf_waddr);
    end

    assign busy           = (state_q != S_IDLE);
    assign error          = err_q;
    assign flag_n         = flag_we & neg_q;
    assign flag_z         = flag_we & zero_q;
    assign mul_long       = long_q;
    assign mul_signed     = sgn_q;
    assign mul_accumulate = acc_q;
    assign mul_set_flags  = set_q;
    assign mul_type       = {long_q, acc_q};
    assign operand_a      = op_a_q;
    assign operand_b      = op_b_q;
    assign acc_hi         = acc_hi_q;
    assign acc_lo         = acc_lo_q;

endmodule

// File: tb/tb_arm7tdmi_mul_sequencer.sv
// Bench for arm7tdmi_mul_sequencer: register file and multiplier stand-ins
// around the DUT, checked cycle by cycle against an arithmetic model.
module tb_arm7tdmi_mul_sequencer;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] instr = '0;
    logic        busy, done, error;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;
    logic        mul_en, mul_long, mul_signed, mul_accumulate, mul_set_flags;
    logic [1:0]  mul_type;
    logic [31:0] operand_a, operand_b, acc_hi, acc_lo;
    logic [31:0] result_hi, result_lo;
    logic        result_ready, negative, zero;
    logic        flag_we, flag_n, flag_z;

    arm7tdmi_mul_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr),
        .busy(busy), .done(done), .error(error),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mul_en(mul_en), .mul_long(mul_long), .mul_signed(mul_signed),
        .mul_accumulate(mul_accumulate), .mul_set_flags(mul_set_flags),
        .mul_type(mul_type), .operand_a(operand_a), .operand_b(operand_b),
        .acc_hi(acc_hi), .acc_lo(acc_lo),
        .result_hi(result_hi), .result_lo(result_lo),
        .result_ready(result_ready), .negative(negative), .zero(zero),
        .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_idle = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register file stand-in: combinational reads, one write port.
    logic [31:0] env_regs [16];
    logic [31:0] exp_regs [16];
    logic        load_en = 1'b0;
    logic [3:0]  load_a = '0;
    logic [31:0] load_d = '0;

    assign rf_rdata_a = env_regs[rf_raddr_a];
    assign rf_rdata_b = env_regs[rf_raddr_b];

    // Multiplier stand-in: answers after st_k cycles of mul_en (0 = never).
    int          st_k = 0;
    int          ecnt = 0;
    logic [31:0] st_hi = '0, st_lo = '0;
    logic        st_n = 1'b0, st_z = 1'b0;

    assign result_ready = mul_en && (st_k > 0) && (ecnt == st_k - 1);
    assign result_hi = st_hi;
    assign result_lo = st_lo;
    assign negative  = st_n;
    assign zero      = st_z;

    always @(posedge clk) begin
        ecnt <= mul_en ? ecnt + 1 : 0;
        if (load_en) env_regs[load_a] <= load_d;
        else if (rf_we) env_regs[rf_waddr] <= rf_wdata;
    end

    typedef struct {
        bit        busy, mul_en, done, error, rf_we, flag_we, n, z;
        bit [3:0]  waddr;
        bit [31:0] wdata;
    } cyc_t;

    cyc_t exp_q[$];
    cyc_t ce;
    logic [31:0] x_opa, x_opb, x_acchi, x_acclo;
    logic        x_long, x_sgn, x_acc, x_set;

    // Single compare process: expected cycles from the queue, idle otherwise.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("busy", busy, ce.busy);
            chk("mul_en", mul_en, ce.mul_en);
            chk("done", done, ce.done);
            chk("error", error, ce.error);
            chk("rf_we", rf_we, ce.rf_we);
            chk("flag_we", flag_we, ce.flag_we);
            if (ce.rf_we) begin
                chk("rf_waddr", rf_waddr, ce.waddr);
                chk("rf_wdata", rf_wdata, ce.wdata);
            end
            if (ce.flag_we) begin
                chk("flag_n", flag_n, ce.n);
                chk("flag_z", flag_z, ce.z);
            end
            if (ce.mul_en) begin
                chk("operand_a", operand_a, x_opa);
                chk("operand_b", operand_b, x_opb);
                chk("acc_hi", acc_hi, x_acchi);
                chk("acc_lo", acc_lo, x_acclo);
                chk("mul_long", mul_long, x_long);
                chk("mul_signed", mul_signed, x_sgn);
                chk("mul_acc", mul_accumulate, x_acc);
                chk("mul_set_flags", mul_set_flags, x_set);
                chk("mul_type", mul_type, {x_long, x_acc});
            end
        end else if (mon_idle) begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_mul_en", mul_en, 1'b0);
            chk("idle_rf_we", rf_we, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_flag_we", flag_we, 1'b0);
        end
    end

    function automatic logic [31:0] mk(input bit lng, input bit u,
                                       input bit a, input bit s,
                                       input logic [3:0] f19,
                                       input logic [3:0] f15,
                                       input logic [3:0] rs,
                                       input logic [3:0] rm);
        return {4'hE, 4'h0, lng, u, a, s, f19, f15, rs, 4'b1001, rm};
    endfunction

    task automatic set_reg(input logic [3:0] a, input logic [31:0] d);
        load_en = 1'b1;
        load_a  = a;
        load_d  = d;
        exp_regs[a] = d;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic chk_regs(input string nm);
        for (int i = 0; i < 16; i++)
            chk(nm, env_regs[i], exp_regs[i]);
    endtask

    // Issue one instruction; k = EXEC cycles until result_ready (0: timeout).
    task automatic run(input logic [31:0] ins, input int k, input bit extra);
        bit          lng, u, a, s;
        logic [31:0] rm, rs, rlo, rhi, lo, hi;
        logic [63:0] p;
        longint      sa, sb;
        bit          n, z;
        int          e0, wlo, whi, dn, last;
        cyc_t        c;
        lng = ins[23];
        u   = ins[22];
        a   = ins[21];
        s   = ins[20];
        rm  = exp_regs[ins[3:0]];
        rs  = exp_regs[ins[11:8]];
        rlo = exp_regs[ins[15:12]];
        rhi = exp_regs[ins[19:16]];
        if (lng) begin
            if (u) begin
                sa = longint'($signed(rm));
                sb = longint'($signed(rs));
                p  = 64'(sa * sb);
            end else begin
                p = {32'd0, rm} * {32'd0, rs};
            end
            if (a) p = p + {rhi, rlo};
            lo = p[31:0];
            hi = p[63:32];
            n  = p[63];
            z  = (p == 64'd0);
        end else begin
            lo = rm * rs + (a ? rlo : 32'd0);
            hi = 32'd0;
            n  = lo[31];
            z  = (lo == 32'd0);
        end
        st_hi = hi; st_lo = lo; st_n = n; st_z = z; st_k = k;
        x_opa = rm; x_opb = rs;
        x_acclo = a ? rlo : 32'd0;
        x_acchi = (a && lng) ? rhi : 32'd0;
        x_long = lng; x_sgn = lng & u; x_acc = a; x_set = s;

        instr = ins;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        instr = '0;

        e0 = 2 + int'(a);
        if (k == 0) begin
            last = e0 + TO;
            for (int cy = 1; cy <= last + 1; cy++) begin
                c = '{default: 0};
                c.busy   = (cy < last);
                c.mul_en = (cy >= e0) && (cy < last);
                c.error  = (cy == last);
                exp_q.push_back(c);
            end
        end else begin
            wlo = e0 + k;
            whi = lng ? wlo + 1 : -1;
            dn  = wlo + 1 + int'(lng);
            for (int cy = 1; cy <= dn + 2; cy++) begin
                c = '{default: 0};
                c.busy   = (cy <= dn);
                c.mul_en = (cy >= e0) && (cy < wlo);
                c.done   = (cy == dn);
                if (cy == wlo) begin
                    c.waddr = lng ? ins[15:12] : ins[19:16];
                    c.wdata = lo;
                    c.rf_we = (c.waddr != 4'hF);
                end
                if (cy == whi) begin
                    c.waddr = ins[19:16];
                    c.wdata = hi;
                    c.rf_we = (c.waddr != 4'hF);
                end
                c.flag_we = s && (cy == (lng ? whi : wlo));
                c.n = c.flag_we & n;
                c.z = c.flag_we & z;
                exp_q.push_back(c);
            end
            if (lng) begin
                if (ins[15:12] != 4'hF) exp_regs[ins[15:12]] = lo;
                if (ins[19:16] != 4'hF) exp_regs[ins[19:16]] = hi;
            end else if (ins[19:16] != 4'hF) begin
                exp_regs[ins[19:16]] = lo;
            end
        end

        if (extra) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            instr = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
            @(posedge clk);
            #1;
            start = 1'b0;
            instr = '0;
        end

        for (int i = 0; i < 300 && exp_q.size() != 0; i++)
            @(posedge clk);
        #1;
        chk("queue_drain", exp_q.size(), 0);
        exp_q.delete();
        chk_regs("regfile");
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ins;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_mul_en", mul_en, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_flag_we", flag_we, 1'b0);
        chk("rst_operand_a", operand_a, 32'd0);
        chk("rst_mul_type", mul_type, 2'd0);
        for (int i = 0; i < 16; i++) set_reg(4'(i), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_idle = 1'b1;

        // MLA R0,R1,R2,R3 S=1: 5*7+10
        set_reg(4'd1, 32'd5);
        set_reg(4'd2, 32'd7);
        set_reg(4'd3, 32'd10);
        run(mk(0, 0, 1, 1, 4'd0, 4'd3, 4'd2, 4'd1), 2, 1'b0);
        chk("lit_mla_r0", env_regs[0], 32'd45);
        chk("lit_mla_model", exp_regs[0], 32'd45);

        // UMLAL R4,R5,R1,R2
        set_reg(4'd1, 32'hFFFF_FFFF);
        set_reg(4'd2, 32'd2);
        set_reg(4'd4, 32'd1);
        set_reg(4'd5, 32'd1);
        run(mk(1, 0, 1, 0, 4'd5, 4'd4, 4'd2, 4'd1), 3, 1'b1);
        chk("lit_umlal_r5", env_regs[5], 32'd2);
        chk("lit_umlal_r4", env_regs[4], 32'hFFFF_FFFF);

        // SMLAL S=1, (-1)*(-1) + (-1) = 0
        set_reg(4'd2, 32'hFFFF_FFFF);
        set_reg(4'd7, 32'hFFFF_FFFF);
        set_reg(4'd8, 32'hFFFF_FFFF);
        run(mk(1, 1, 1, 1, 4'd8, 4'd7, 4'd2, 4'd1), 1, 1'b0);
        chk("lit_smlal_hi", env_regs[8], 32'd0);
        chk("lit_smlal_lo", env_regs[7], 32'd0);
        chk("lit_smlal_z", st_z, 1'b1);

        // UMULL R6,R6: hi write lands last
        set_reg(4'd1, 32'h0001_0000);
        set_reg(4'd2, 32'h0001_0000);
        run(mk(1, 0, 0, 0, 4'd6, 4'd6, 4'd2, 4'd1), 4, 1'b0);
        chk("lit_umull_r6", env_regs[6], 32'd1);

        // Short multiply into R15: write dropped, flags kept
        run(mk(0, 1, 0, 1, 4'd15, 4'd0, 4'd2, 4'd1), 1, 1'b1);

        // Timeout with no result
        run(mk(0, 0, 1, 0, 4'd3, 4'd4, 4'd5, 4'd6), 0, 1'b0);

        // Reset while in EXEC
        mon_idle = 1'b0;
        st_k = 0;
        instr = mk(0, 0, 0, 1, 4'd10, 4'd0, 4'd2, 4'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        instr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstx_mul_en_before", mul_en, 1'b1);
        chk("rstx_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstx_mul_en", mul_en, 1'b0);
        chk("rstx_busy", busy, 1'b0);
        chk("rstx_rf_we", rf_we, 1'b0);
        chk("rstx_done", done, 1'b0);
        chk("rstx_error", error, 1'b0);
        chk("rstx_operand_a", operand_a, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstx_busy_later", busy, 1'b0);
        chk_regs("rstx_regfile");
        mon_idle = 1'b1;

        // Randomised instructions
        for (int t = 0; t < 40; t++) begin
            for (int j = 0; j < 3; j++)
                set_reg(4'($urandom_range(0, 15)), pick());
            ins = mk($urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            ins[31:24] = 8'($urandom);
            ins[7:4]   = 4'($urandom);
            run(ins, (t == 20) ? 0 : $urandom_range(1, 6),
                1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
